branch_unit: RTL and testbench

//  Parametrised branch resolution + prediction unit for the RISC-V core.
//  - Resolves all six B-type conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU) from funct3, not one fixed compare.
//  - Holds a direct-mapped table of saturating counters and branch targets (BHT/BTB) that the fetch stage queries.
//  - Reports mispredicts so the control FSM can redirect the PC.

---
 rtl/branch_unit_if.sv | 35 +++
 rtl/branch_unit.sv | 132 +++++++++++++
 tb/tb_branch_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/branch_unit_if.sv
// Bundle of the fetch-lookup and resolve signals between the core and branch_unit.
interface branch_unit_if #(
  parameter int XLEN = 32
);
  // Fetch-side lookup
  logic [XLEN-1:0] lk_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  // Resolve request
  logic            rs_valid;
  logic [XLEN-1:0] rs_pc;
  logic [2:0]      rs_funct3;
  logic [XLEN-1:0] rs_a;
  logic [XLEN-1:0] rs_b;
  logic [XLEN-1:0] rs_imm;
  logic            rs_pred_taken;
  logic [XLEN-1:0] rs_pred_tgt;
  // Registered resolve result
  logic            res_valid;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic            mispredict;
  logic            illegal;

  modport master (
    output lk_pc, rs_valid, rs_pc, rs_funct3, rs_a, rs_b, rs_imm, rs_pred_taken, rs_pred_tgt,
    input  pred_hit, pred_taken, pred_target, res_valid, res_taken, res_target, mispredict, illegal
  );

  modport slave (
    input  lk_pc, rs_valid, rs_pc, rs_funct3, rs_a, rs_b, rs_imm, rs_pred_taken, rs_pred_tgt,
    output pred_hit, pred_taken, pred_target, res_valid, res_taken, res_target, mispredict, illegal
  );
endinterface

// File: rtl/branch_unit.sv
// Branch resolution for all six B-type conditions plus a direct-mapped
// BHT/BTB (saturating counter + target per entry) queried by fetch.
module branch_unit #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int XLEN    = 32
) (
  input logic         clk,
  input logic         rst,
  branch_unit_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  logic             tbl_vld [ENTRIES];
  logic [TAG_W-1:0] tbl_tag [ENTRIES];
  logic [CNT_W-1:0] tbl_cnt [ENTRIES];
  logic [XLEN-1:0]  tbl_tgt [ENTRIES];

  logic [IDX_W-1:0] lk_idx, rs_idx;
  logic [TAG_W-1:0] lk_tag, rs_tag;
  logic             lk_hit, rs_hit;
  logic             lk_lsb_unused;

  logic signed [XLEN-1:0] a_s, b_s;
  logic [XLEN-1:0]  tgt_br, tgt_seq;
  logic             cond_taken, legal, upd_en, mispred;
  logic [CNT_W-1:0] cnt_base, cnt_next;

  logic             vld_p1, taken_p1, mispred_p1, illegal_p1;
  logic [XLEN-1:0]  tgt_p1;

  assign lk_idx        = bus.lk_pc[IDX_W+1:2];
  assign lk_tag        = bus.lk_pc[XLEN-1:IDX_W+2];
  assign lk_lsb_unused = ^bus.lk_pc[1:0];
  assign rs_idx        = bus.rs_pc[IDX_W+1:2];
  assign rs_tag        = bus.rs_pc[XLEN-1:IDX_W+2];

  // Fetch lookup reads the table as it stands before this edge's update
  assign lk_hit          = tbl_vld[lk_idx] && (tbl_tag[lk_idx] == lk_tag);
  assign bus.pred_hit    = lk_hit;
  assign bus.pred_taken  = lk_hit && tbl_cnt[lk_idx][CNT_W-1];
  assign bus.pred_target = lk_hit ? tbl_tgt[lk_idx] : '0;

  assign a_s     = $signed(bus.rs_a);
  assign b_s     = $signed(bus.rs_b);
  assign tgt_br  = bus.rs_pc + bus.rs_imm;
  assign tgt_seq = bus.rs_pc + XLEN'(4);

  // Condition evaluation; funct3 010/011 are not branches
  always_comb begin
    cond_taken = 1'b0;
    legal      = 1'b1;
    unique case (bus.rs_funct3)
      3'b000:  cond_taken = (bus.rs_a == bus.rs_b);
      3'b001:  cond_taken = (bus.rs_a != bus.rs_b);
      3'b100:  cond_taken = (a_s < b_s);
      3'b101:  cond_taken = (a_s >= b_s);
      3'b110:  cond_taken = (bus.rs_a < bus.rs_b);
      3'b111:  cond_taken = (bus.rs_a >= bus.rs_b);
      default: legal      = 1'b0;
    endcase
  end

  // Counter step and redirect decision; a tag miss restarts from the weak value
  always_comb begin
    upd_en   = bus.rs_valid && legal;
    rs_hit   = tbl_vld[rs_idx] && (tbl_tag[rs_idx] == rs_tag);
    cnt_base = rs_hit ? tbl_cnt[rs_idx] : CNT_WEAK;
    cnt_next = cond_taken ? sat_inc(cnt_base) : sat_dec(cnt_base);
    if (legal)
      mispred = (cond_taken != bus.rs_pred_taken) ||
                (cond_taken && (bus.rs_pred_tgt != tgt_br));
    else
      mispred = bus.rs_pred_taken;
  end

  // Table control state: valid, tag, counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_vld[i] <= 1'b0;
        tbl_cnt[i] <= CNT_WEAK;
      end
    end else if (upd_en) begin
      tbl_vld[rs_idx] <= 1'b1;
      tbl_tag[rs_idx] <= rs_tag;
      tbl_cnt[rs_idx] <= cnt_next;
    end
  end

  // Branch targets are only written on a taken resolve; never reset
  always_ff @(posedge clk) begin
    if (!rst && upd_en && cond_taken)
      tbl_tgt[rs_idx] <= tgt_br;
  end

  // ---- stage p0 -> p1: registered resolve result ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      taken_p1   <= 1'b0;
      tgt_p1     <= '0;
      mispred_p1 <= 1'b0;
      illegal_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.rs_valid;
      if (bus.rs_valid) begin
        taken_p1   <= cond_taken;
        tgt_p1     <= cond_taken ? tgt_br : tgt_seq;
        mispred_p1 <= mispred;
        illegal_p1 <= !legal;
      end
    end
  end

  assign bus.res_valid  = vld_p1;
  assign bus.res_taken  = taken_p1;
  assign bus.res_target = tgt_p1;
  assign bus.mispredict = mispred_p1;
  assign bus.illegal    = illegal_p1;
endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit (ENTRIES=16, CNT_W=2, XLEN=32).
module tb_branch_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  branch_unit_if #(.XLEN(32)) bus ();

  branch_unit #(.ENTRIES(16), .CNT_W(2), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rs(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptgt);
    bus.rs_valid      = 1'b1;
    bus.rs_pc         = pc;
    bus.rs_funct3     = f3;
    bus.rs_a          = a;
    bus.rs_b          = b;
    bus.rs_imm        = imm;
    bus.rs_pred_taken = pt;
    bus.rs_pred_tgt   = ptgt;
  endtask

  // One resolve cycle; result is registered and visible after the edge
  task automatic resolve(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptgt);
    set_rs(pc, f3, a, b, imm, pt, ptgt);
    tick();
    bus.rs_valid = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    bus.lk_pc = pc;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.lk_pc = '0;
    // rs_valid together with rst must store nothing
    set_rs(32'h50, 3'b000, 32'd1, 32'd1, 32'd8, 1'b0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    bus.rs_valid = 1'b0;
    #1;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_taken", bus.res_taken, 0);
    chk("rst_res_target", bus.res_target, 0);
    chk("rst_mispredict", bus.mispredict, 0);
    chk("rst_illegal", bus.illegal, 0);
    look(32'h0);
    chk("rst_hit", bus.pred_hit, 0);
    chk("rst_ptaken", bus.pred_taken, 0);
    chk("rst_ptarget", bus.pred_target, 0);
    look(32'h50);
    chk("rst_upd_blocked_hit", bus.pred_hit, 0);

    // BGE signed vs BGEU unsigned
    resolve(32'h18, 3'b101, 32'hffffffff, 32'h0, 32'd36, 1'b0, 32'h0);
    chk("bge_valid", bus.res_valid, 1);
    chk("bge_taken", bus.res_taken, 0);
    chk("bge_target", bus.res_target, 32'h1c);
    chk("bge_mispred", bus.mispredict, 0);
    resolve(32'h18, 3'b111, 32'hffffffff, 32'h0, 32'd36, 1'b0, 32'h0);
    chk("bgeu_taken", bus.res_taken, 1);
    chk("bgeu_target", bus.res_target, 32'h3c);
    chk("bgeu_mispred_dir", bus.mispredict, 1);

    // Mispredict on wrong target, none on right target
    resolve(32'h18, 3'b111, 32'hffffffff, 32'h0, 32'd36, 1'b1, 32'h40);
    chk("mp_wrong_tgt", bus.mispredict, 1);
    resolve(32'h18, 3'b111, 32'hffffffff, 32'h0, 32'd36, 1'b1, 32'h3c);
    chk("mp_right_tgt", bus.mispredict, 0);

    // Idle cycle: res_valid drops, data holds
    tick();
    chk("idle_valid", bus.res_valid, 0);
    chk("idle_taken_hold", bus.res_taken, 1);
    chk("idle_target_hold", bus.res_target, 32'h3c);

    // BLT signed / BLTU unsigned, BEQ, BNE
    resolve(32'h100, 3'b100, 32'hffffffff, 32'h1, 32'd8, 1'b0, 32'h0);
    chk("blt_taken", bus.res_taken, 1);
    chk("blt_target", bus.res_target, 32'h108);
    resolve(32'h100, 3'b110, 32'hffffffff, 32'h1, 32'd8, 1'b0, 32'h0);
    chk("bltu_taken", bus.res_taken, 0);
    chk("bltu_target", bus.res_target, 32'h104);
    resolve(32'h100, 3'b000, 32'h7, 32'h8, 32'd8, 1'b0, 32'h0);
    chk("beq_ne_taken", bus.res_taken, 0);
    resolve(32'h100, 3'b001, 32'h7, 32'h8, 32'd8, 1'b0, 32'h0);
    chk("bne_taken", bus.res_taken, 1);

    // Target wrap modulo 2^32
    resolve(32'hfffffffc, 3'b000, 32'h1, 32'h1, 32'd8, 1'b0, 32'h0);
    chk("wrap_br_target", bus.res_target, 32'h4);
    resolve(32'hfffffffc, 3'b001, 32'h1, 32'h1, 32'd8, 1'b0, 32'h0);
    chk("wrap_seq_target", bus.res_target, 32'h0);

    // Saturation: three taken -> 11, fourth keeps 11, two not-taken -> 01
    for (int i = 0; i < 3; i++)
      resolve(32'h30, 3'b000, 32'h5, 32'h5, 32'hffffffd0, 1'b0, 32'h0);
    chk("sat_res_target", bus.res_target, 32'h0);
    look(32'h30);
    chk("sat_hit", bus.pred_hit, 1);
    chk("sat_ptaken", bus.pred_taken, 1);
    chk("sat_ptarget", bus.pred_target, 32'h0);
    resolve(32'h30, 3'b000, 32'h5, 32'h5, 32'hffffffd0, 1'b0, 32'h0);
    resolve(32'h30, 3'b001, 32'h5, 32'h5, 32'hffffffd0, 1'b1, 32'h0);
    chk("sat_nt_target", bus.res_target, 32'h34);
    chk("sat_nt_mispred", bus.mispredict, 1);
    look(32'h30);
    chk("sat_after1nt_ptaken", bus.pred_taken, 1);
    resolve(32'h30, 3'b001, 32'h5, 32'h5, 32'hffffffd0, 1'b1, 32'h0);
    look(32'h30);
    chk("sat_after2nt_ptaken", bus.pred_taken, 0);
    chk("sat_after2nt_hit", bus.pred_hit, 1);

    // Alias: 0x08 and 0x48 share index 2
    resolve(32'h08, 3'b000, 32'h1, 32'h1, 32'd16, 1'b0, 32'h0);
    look(32'h08);
    chk("alias_train_hit", bus.pred_hit, 1);
    chk("alias_train_ptaken", bus.pred_taken, 1);
    chk("alias_train_ptarget", bus.pred_target, 32'h18);
    resolve(32'h48, 3'b001, 32'h1, 32'h1, 32'd16, 1'b0, 32'h0);
    look(32'h08);
    chk("alias_old_hit", bus.pred_hit, 0);
    look(32'h48);
    chk("alias_new_hit", bus.pred_hit, 1);
    chk("alias_new_ptaken", bus.pred_taken, 0);
    chk("alias_new_ptarget", bus.pred_target, 32'h18);

    // Illegal funct3: table untouched
    resolve(32'h48, 3'b010, 32'h1, 32'h1, 32'd16, 1'b1, 32'h58);
    chk("ill_valid", bus.res_valid, 1);
    chk("ill_flag", bus.illegal, 1);
    chk("ill_taken", bus.res_taken, 0);
    chk("ill_mispred", bus.mispredict, 1);
    look(32'h48);
    chk("ill_table_ptaken", bus.pred_taken, 0);
    chk("ill_table_hit", bus.pred_hit, 1);
    resolve(32'h60, 3'b011, 32'h1, 32'h1, 32'd16, 1'b0, 32'h0);
    chk("ill011_flag", bus.illegal, 1);
    chk("ill011_mispred", bus.mispredict, 0);
    look(32'h60);
    chk("ill011_no_store", bus.pred_hit, 0);

    // Read-before-write on the same index
    set_rs(32'h60, 3'b000, 32'h1, 32'h1, 32'd16, 1'b0, 32'h0);
    look(32'h60);
    chk("rbw_pre_hit", bus.pred_hit, 0);
    tick();
    bus.rs_valid = 1'b0;
    #1;
    chk("rbw_post_hit", bus.pred_hit, 1);
    chk("rbw_post_ptarget", bus.pred_target, 32'h70);
    chk("legal_clears_illegal", bus.illegal, 0);

    // Reset with rs_valid: reset wins
    rst = 1'b1;
    set_rs(32'h70, 3'b000, 32'h1, 32'h1, 32'd16, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    bus.rs_valid = 1'b0;
    #1;
    chk("rst2_res_valid", bus.res_valid, 0);
    chk("rst2_res_target", bus.res_target, 0);
    look(32'h70);
    chk("rst2_no_store", bus.pred_hit, 0);
    look(32'h48);
    chk("rst2_cleared", bus.pred_hit, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
